// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store front end: access sizes,
// response error codes and the access-unit FSM states.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_RMW_WRITE
  } mau_state_t;

  // Size code 11 behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering between a 32-bit memory word and a sub-word access:
// load extraction with sign/zero extension, and store lane merge.
module lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_word[8*addr_lo +: 8];
  assign half_sel = mem_word[16*addr_lo[1] +: 16];

  always_comb begin
    load_data = mem_word;
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
      default: load_data = mem_word;
    endcase
  end

  // Each lane takes store data when addressed, otherwise keeps the memory byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       hit;
    logic [7:0] src;

    assign hit = is_word(size)
              || (size == SZ_HALF && addr_lo[1] == LANE[1])
              || (size == SZ_BYTE && addr_lo == LANE);
    assign src = is_word(size)     ? store_data[8*gi +: 8] :
                 (size == SZ_HALF) ? store_data[8*(gi % 2) +: 8] :
                                     store_data[7:0];
    assign merged_word[8*gi +: 8] = hit ? src : mem_word[8*gi +: 8];
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end: turns byte-addressed requests into word
// accesses, with a read-modify-write pass for byte and half stores.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int MEM_WORDS = 301,
  parameter int ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_writeData,
  output logic              mem_memWriteF,
  output logic              mem_memReadF,
  input  logic [31:0]       mem_readData
);

  mau_state_t  state_reg, state_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]  rsp_err_reg, rsp_err_next;
  logic [31:0] merge_reg, merge_next;
  logic [31:0] index_reg, index_next;

  logic [31:0] req_index;
  logic [1:0]  err_code;
  logic        accept;
  logic        sub_store;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_index = 32'(req_addr >> 2);
  assign sub_store = req_write && !is_word(req_size);
  assign req_ready = reset_n && (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    err_code = ERR_OK;
    if ((req_size == SZ_HALF && req_addr[0]) ||
        (is_word(req_size) && req_addr[1:0] != 2'b00))
      err_code = ERR_MISALIGN;
    else if ((req_addr >> 2) >= ADDR_W'(MEM_WORDS))
      err_code = ERR_RANGE;
  end

  lane_align u_lane_align (
    .addr_lo     (req_addr[1:0]),
    .size        (req_size),
    .is_signed   (req_signed),
    .mem_word    (mem_readData),
    .store_data  (req_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= ERR_OK;
      merge_reg     <= '0;
      index_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      merge_reg     <= merge_next;
      index_reg     <= index_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = '0;
    rsp_err_next   = ERR_OK;
    merge_next     = merge_reg;
    index_next     = index_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (err_code != ERR_OK) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = err_code;
          end else if (sub_store) begin
            merge_next = merged_word;
            index_next = req_index;
            state_next = ST_RMW_WRITE;
          end else begin
            rsp_valid_next = 1'b1;
            rsp_rdata_next = req_write ? 32'h0 : load_data;
          end
        end
      end
      ST_RMW_WRITE: begin
        state_next     = ST_IDLE;
        rsp_valid_next = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Enables are gated by reset so an in-flight RMW write is dropped.
  always_comb begin
    mem_memReadF  = 1'b0;
    mem_memWriteF = 1'b0;
    mem_address   = req_index;
    mem_writeData = req_wdata;
    if (reset_n) begin
      if (state_reg == ST_RMW_WRITE) begin
        mem_memWriteF = 1'b1;
        mem_address   = index_reg;
        mem_writeData = merge_reg;
      end else if (req_valid && err_code == ERR_OK) begin
        if (req_write && is_word(req_size))
          mem_memWriteF = 1'b1;
        else
          mem_memReadF = 1'b1;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the word-addressed data memory in the MEM stage.
- Accepts byte-addressed requests from the EX/MEM pipeline register and converts them to word-indexed memory accesses.
- Supports byte, half and word sizes; sub-word stores use a two-cycle read-modify-write, since the memory only writes whole 32-bit words.
- Reports misaligned and out-of-range accesses instead of touching memory.

Parameters:
- MEM_WORDS, 301, number of 32-bit words in the data memory; valid word indices are 0..MEM_WORDS-1.
- ADDR_W, 32, request byte-address width.

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE and out of reset
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified for sub-word stores
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result, 0 for stores and errors
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range
- mem_address  out  32  word index (req_addr >> 2)
- mem_writeData  out  32  full word to write
- mem_memWriteF  out  1  memory write enable
- mem_memReadF  out  1  memory read enable
- mem_readData  in  32  combinational memory read data

Behaviour:
- The unit is synchronous, with active-low reset on the rising edge of clock.
- Reset values: state IDLE; rsp_valid 0; rsp_rdata 0; rsp_err 00; merge buffer 0.
- During reset, mem_memWriteF, mem_memReadF and req_ready are forced to 0.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by req_addr[1:0]; the half lane is selected by req_addr[1].
- A request is accepted when req_valid && req_ready at a rising edge.
- Error checks are applied in IDLE, combinationally, in this priority order:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: word index >= MEM_WORDS.
  - On either error: no memory enables are asserted. The next cycle gives rsp_valid=1, rsp_rdata=0 and the error code.
- FSM states: IDLE, RMW_WRITE.
- IDLE, load:
  - mem_memReadF=1 and mem_address=word index, both combinationally.
  - At the accept edge, the selected lane is extracted from mem_readData. It is sign-extended if req_signed, otherwise zero-extended. Word loads are passed through.
  - The result is registered into rsp_rdata. rsp_valid pulses the following cycle.
  - Load latency is 1 cycle.
- IDLE, word store:
  - mem_memWriteF=1 and mem_writeData=req_wdata, combinationally; the memory writes at the accept edge.
  - rsp_valid pulses next cycle with rsp_rdata=0.
  - Latency is 1 cycle and the state stays IDLE.
- IDLE, byte/half store:
  - mem_memReadF=1.
  - The merged word is mem_readData with the target lane replaced by req_wdata[7:0] or req_wdata[15:0].
  - At the accept edge, the merged word and the word index are latched and the FSM goes to RMW_WRITE.
- RMW_WRITE:
  - req_ready=0 and mem_memWriteF=1.
  - mem_address and mem_writeData come from the latched values.
  - At the next edge the FSM returns to IDLE and rsp_valid pulses the following cycle.
  - Total latency is 2 cycles; the upstream pipeline must stall while req_ready=0.
- Back-to-back requests in IDLE are accepted every cycle; a response pulse may coincide with a new accept.
- Reset asserted in RMW_WRITE aborts the write: no memory write occurs on that edge and no rsp_valid is produced.
- mem_memWriteF and mem_memReadF are never both high in the same cycle.
- With req_valid=0 in IDLE, all memory enables are 0.

Decomposition:
- Shared package (mips_mem_pkg) holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - error codes ERR_OK/ERR_MISALIGN/ERR_RANGE
  - the FSM state encoding
- One natural sub-module, lane_align: a pure combinational block that does load extraction/extension and store lane merge, given addr[1:0], size, sign, memory word and store data.
- The FSM, error check and registers stay in mem_access_unit.

Test Plan:
- Word store then load:
  - sw 0xDEADBEEF to 0x10 → mem index 4 written with 0xDEADBEEF.
  - lw 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=00, rsp_valid 1 cycle after accept.
- Sub-word loads (word 4 = 0xDEADBEEF):
  - lb 0x13 signed → 0xFFFFFFDE.
  - lbu 0x12 → 0x000000AD.
  - lh 0x10 signed → 0xFFFFBEEF.
  - lhu 0x12 → 0x0000DEAD.
- Byte store RMW:
  - sb 0x55 to 0x11 over 0xDEADBEEF → req_ready low exactly 1 cycle, memory write 0xDEAD55EF to index 4, rsp_valid 2 cycles after accept.
- Misalignment and range:
  - lw 0x12 → rsp_err=01.
  - sh 0x11 → rsp_err=01.
  - sw 0x4B4 (index 301) → rsp_err=10.
  - In all three cases no memory enable is asserted and rsp_rdata=0.
- Reset mid-RMW:
  - sh 0x1234 to 0x20, then reset_n=0 during RMW_WRITE → index 8 unchanged, state IDLE, rsp_valid=0.
- Back-to-back: lw, sw, lw on consecutive cycles → three rsp_valid pulses on consecutive cycles; the second lw returns the newly stored data.
